serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, sysclk cycles per serial bit (50 MHz / 9600 baud).
REQ-002 Parameter HALF_BIT, default CLKS_PER_BIT/2 (2604), offset from the start-bit falling edge to the start-bit sample point.
REQ-003 sysclk  in  1  system clock; all flops on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 serialIn  in  1  raw asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_ready  in  1  consumer accepts rx_data in any cycle where rx_valid and rx_ready are both 1.
REQ-007 err_clr  in  1  single-cycle clear of the sticky overrun flag.
REQ-008 rx_data  out  8  last accepted received byte.
REQ-009 rx_valid  out  1  rx_data holds an unconsumed byte.
REQ-010 rx_busy  out  1  a frame is in progress (state other than IDLE).
REQ-011 frame_err  out  1  one-cycle pulse when the stop bit samples 0.
REQ-012 overrun  out  1  sticky: a byte completed while an earlier byte was still unconsumed.

Function
REQ-013 serialIn passes through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle latency).
REQ-014 States: IDLE, START, DATA, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1) and one 3-bit data index.
REQ-015 IDLE: synchronized line 0 -> START with the bit counter cleared; otherwise remain in IDLE.
REQ-016 START: at count HALF_BIT-1, sample the line; 1 -> IDLE (glitch, no output); 0 -> DATA with the counter cleared and index 0.
REQ-017 DATA: at count CLKS_PER_BIT-1, sample into the shift register at position index (LSB first) and clear the counter; after index 7 -> STOP.
REQ-018 STOP: at count CLKS_PER_BIT-1, sample the line; 1 -> deliver the byte and go to IDLE; 0 -> pulse frame_err, discard the byte, go to BREAK.
REQ-019 BREAK: remain until the synchronized line is 1, then IDLE; a low line held for a full frame is never delivered as data.
REQ-020 Deliver: if rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle, load rx_data and set rx_valid=1 in the next cycle.
REQ-021 Deliver while rx_valid=1 and rx_ready=0: set overrun, drop the new byte, and leave rx_data/rx_valid unchanged.
REQ-022 rx_valid clears in the cycle after rx_valid&rx_ready unless a delivery occurs in that same cycle (REQ-020).
REQ-023 overrun clears on err_clr; an overrun event in the same cycle as err_clr takes priority (flag stays 1).
REQ-024 Byte-end to rx_valid latency: 1 cycle after the stop-bit sample.
REQ-025 Counter width: $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-026 reset=0 forces IDLE, counter=0, index=0, shift register=0, rx_data=0x00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, and both synchronizer flops=1 (line idle).
REQ-027 Reset asserted mid-frame abandons the frame; the first falling edge after release starts a fresh frame.

Structure
REQ-028 Shared package serial_pkg holds CLKS_PER_BIT_9600=5208, the state encoding, and the frame length (10 bits).
REQ-029 One sub-module, bit_sync (2-flop synchronizer, reset value 1); everything else is inline.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-030 Send 0x41 with rx_ready=1 -> one rx_valid pulse, rx_data=0x41 one cycle after the stop sample, frame_err=0, overrun=0.
REQ-031 4-cycle low glitch on idle line -> returns to IDLE at the start sample, rx_valid and rx_busy are 0 afterwards, no frame_err.
REQ-032 Send 0x55 with stop bit 0, line held low 40 cycles -> frame_err pulse of 1 cycle, no rx_valid, stays in BREAK until the line goes high, next frame 0xA5 received correctly.
REQ-033 rx_ready=0, send 0x12 then 0x34 -> rx_data=0x12 held, overrun=1; err_clr pulse -> overrun=0.
REQ-034 rx_ready pulsed in the exact cycle 0x34 completes after 0x12 -> rx_data=0x34, rx_valid stays 1, overrun=0.
REQ-035 reset asserted during bit 4 of 0x7E -> all outputs 0 at once; after release, 0x7E resent and received intact.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial_rx UART receiver.
// Holds the 9600-baud divider, frame length and receiver FSM states.
package serial_pkg;

  localparam int CLKS_PER_BIT_9600 = 5208;
  localparam int FRAME_BITS        = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous level, resetting to 1.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver with valid/ready output, frame error and overrun flags.
// Ports: sysclk, reset (async low), serialIn, rx_ready, err_clr in;
// rx_data, rx_valid, rx_busy, frame_err, overrun out.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  logic            line;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            deliver;
  logic            stop_bad;

  bit_sync u_sync (
    .clk   (sysclk),
    .rst_n (reset),
    .d     (serialIn),
    .q     (line)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!line) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line back high at mid start bit was only a glitch.
          state_d = line ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = line;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (line) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_BRK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BRK: begin
        // Wait out a held-low line so it never restarts a frame.
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A drop beats a same-cycle clear so the event is not lost.
      if (deliver && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx at 16 clocks per bit.
// Directed frame table plus hand-written corner sequences.
module tb_serial_rx;
  import serial_pkg::*;

  localparam int BITC = 16;
  localparam int FRC  = FRAME_BITS * BITC;

  logic       clk;
  logic       reset;
  logic       serialIn;
  logic       rx_ready;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  serial_rx #(
    .CLKS_PER_BIT (BITC),
    .HALF_BIT     (8)
  ) dut (
    .sysclk    (clk),
    .reset     (reset),
    .serialIn  (serialIn),
    .rx_ready  (rx_ready),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         valid_rises = 0;
  int         ferr_pulses = 0;
  int         ferr_cycles = 0;
  logic [7:0] last_data   = '0;
  time        rise_time   = 0;
  logic       prev_valid  = 1'b0;
  logic       prev_ferr   = 1'b0;
  time        t_start     = 0;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      rise_time = $time;
      last_data = rx_data;
    end
    if (frame_err) ferr_cycles++;
    if (frame_err && !prev_ferr) ferr_pulses++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge. rdy_at>=0 pulses rx_ready at that
  // cycle only; rst_at>=0 aborts with a reset; hold keeps the last level.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int rdy_at, input int rst_at,
                            input bit hold);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    t_start = $time;
    for (int i = 0; i < FRC; i++) begin
      serialIn = fr[i / BITC];
      if (rdy_at >= 0) rx_ready = (i == rdy_at);
      if (i == rst_at) begin
        chk("rst_busy_before", {31'd0, rx_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_outputs_zero",
            {20'd0, rx_data, rx_valid, rx_busy, frame_err, overrun}, 32'd0);
        @(negedge clk);
        serialIn = 1'b1;
        reset    = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (!hold) serialIn = 1'b1;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, f0, c0;

    vecs[0] = '{8'h41, 1'b1, 8'h41, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 8'h00, 0, 1};

    reset    = 1'b0;
    serialIn = 1'b1;
    rx_ready = 1'b1;
    err_clr  = 1'b0;
    idle(3);
    chk("reset_outputs",
        {20'd0, rx_data, rx_valid, rx_busy, frame_err, overrun}, 32'd0);
    reset = 1'b1;
    idle(5);

    foreach (vecs[k]) begin
      v0 = valid_rises;
      f0 = ferr_pulses;
      c0 = ferr_cycles;
      send_frame(vecs[k].tx, vecs[k].stop, -1, -1, 1'b0);
      idle(20);
      chk($sformatf("vec%0d_valid", k), valid_rises - v0, vecs[k].exp_valid);
      if (vecs[k].exp_valid != 0) begin
        chk($sformatf("vec%0d_data", k), {24'd0, last_data},
            {24'd0, vecs[k].exp_data});
        chk($sformatf("vec%0d_latency", k), 32'(rise_time - t_start),
            32'd1550);
      end
      chk($sformatf("vec%0d_ferr", k), ferr_pulses - f0, vecs[k].exp_ferr);
      chk($sformatf("vec%0d_ferr_w", k), ferr_cycles - c0, vecs[k].exp_ferr);
      chk($sformatf("vec%0d_ovr", k), {31'd0, overrun}, 32'd0);
      chk($sformatf("vec%0d_busy", k), {31'd0, rx_busy}, 32'd0);
    end

    // Short low glitch on an idle line.
    v0 = valid_rises;
    f0 = ferr_pulses;
    serialIn = 1'b0;
    idle(4);
    serialIn = 1'b1;
    idle(2);
    chk("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
    idle(20);
    chk("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_no_out", valid_rises - v0, 32'd0);
    chk("glitch_no_ferr", ferr_pulses - f0, 32'd0);

    // Bad stop bit followed by a held-low line.
    v0 = valid_rises;
    f0 = ferr_pulses;
    c0 = ferr_cycles;
    send_frame(8'h55, 1'b0, -1, -1, 1'b1);
    idle(40);
    chk("brk_ferr_pulse", ferr_pulses - f0, 32'd1);
    chk("brk_ferr_width", ferr_cycles - c0, 32'd1);
    chk("brk_no_valid", valid_rises - v0, 32'd0);
    chk("brk_busy", {31'd0, rx_busy}, 32'd1);
    serialIn = 1'b1;
    idle(4);
    chk("brk_exit", {31'd0, rx_busy}, 32'd0);
    send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
    idle(20);
    chk("brk_next_valid", valid_rises - v0, 32'd1);
    chk("brk_next_data", {24'd0, last_data}, 32'hA5);
    chk("brk_next_ferr", ferr_pulses - f0, 32'd1);

    // Overrun with the consumer stalled.
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, -1, -1, 1'b0);
    idle(10);
    send_frame(8'h34, 1'b1, -1, -1, 1'b0);
    idle(10);
    chk("ovr_data", {24'd0, rx_data}, 32'h12);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
    chk("ovr_clr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_clr_data", {24'd0, rx_data}, 32'h12);

    // Consume in the exact cycle the next byte lands.
    send_frame(8'h34, 1'b1, FRC - 6, -1, 1'b0);
    idle(10);
    chk("same_cyc_data", {24'd0, rx_data}, 32'h34);
    chk("same_cyc_valid", {31'd0, rx_valid}, 32'd1);
    chk("same_cyc_ovr", {31'd0, overrun}, 32'd0);
    rx_ready = 1'b1;
    idle(2);
    chk("drain_valid", {31'd0, rx_valid}, 32'd0);

    // Reset in the middle of data bit 4.
    v0 = valid_rises;
    send_frame(8'h7E, 1'b1, -1, 5 * BITC + 8, 1'b0);
    idle(10);
    chk("rst_abandon", valid_rises - v0, 32'd0);
    send_frame(8'h7E, 1'b1, -1, -1, 1'b0);
    idle(20);
    chk("rst_resend_valid", valid_rises - v0, 32'd1);
    chk("rst_resend_data", {24'd0, last_data}, 32'h7E);
    chk("rst_resend_ferr", {31'd0, frame_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
